// File: rtl/alarm_time_setter.sv
// Alarm time setter: owns the committed alarm_hours/alarm_minutes registers,
// edits shadow copies with set/up/down pulses while in alarm-set mode, and
// drives six 7-segment digits (HH MM 'A' 'L').

// Single 7-seg digit: BCD value to {a..g}, forced blank on request.
module seg7_digit (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    // Decode 0-9; anything else or a blank request shows nothing.
    always_comb begin
        seg = 7'b0000000;
        if (!blank) begin
            case (digit)
                4'd0:    seg = 7'b1111110;
                4'd1:    seg = 7'b0110000;
                4'd2:    seg = 7'b1101101;
                4'd3:    seg = 7'b1111001;
                4'd4:    seg = 7'b0110011;
                4'd5:    seg = 7'b1011011;
                4'd6:    seg = 7'b1011111;
                4'd7:    seg = 7'b1110000;
                4'd8:    seg = 7'b1111111;
                4'd9:    seg = 7'b1111011;
                default: seg = 7'b0000000;
            endcase
        end
    end
endmodule

module alarm_time_setter #(
    parameter logic [1:0] MODE_ID     = 2'd1,
    parameter logic [4:0] RST_HOURS   = 5'd0,
    parameter logic [5:0] RST_MINUTES = 6'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] currentMode,
    input  logic       real_quarter,
    input  logic       pulsed_set,
    input  logic       pulsed_up,
    input  logic       pulsed_down,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic [1:0] alarm_state,
    output logic [6:0] disp0,
    output logic [6:0] disp1,
    output logic [6:0] disp2,
    output logic [6:0] disp3,
    output logic [6:0] disp4,
    output logic [6:0] disp5
);
    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] sh_hours;
    logic [5:0] sh_minutes;
    logic       active;
    logic       inc, dec;

    assign active = (currentMode == MODE_ID);
    // Exactly one of up/down edits; both together cancel out.
    assign inc    = pulsed_up & ~pulsed_down;
    assign dec    = pulsed_down & ~pulsed_up;

    // Mode FSM: shadows load on entry, commit on the final set, discard on mode exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            alarm_hours   <= RST_HOURS;
            alarm_minutes <= RST_MINUTES;
            sh_hours      <= RST_HOURS;
            sh_minutes    <= RST_MINUTES;
        end else if (!active) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pulsed_set) begin
                        state      <= SET_HOUR;
                        sh_hours   <= alarm_hours;
                        sh_minutes <= alarm_minutes;
                    end
                end
                SET_HOUR: begin
                    if (pulsed_set)
                        state <= SET_MIN;
                    else if (inc)
                        sh_hours <= (sh_hours == 5'd23) ? 5'd0 : sh_hours + 5'd1;
                    else if (dec)
                        sh_hours <= (sh_hours == 5'd0) ? 5'd23 : sh_hours - 5'd1;
                end
                SET_MIN: begin
                    if (pulsed_set) begin
                        state         <= IDLE;
                        alarm_hours   <= sh_hours;
                        alarm_minutes <= sh_minutes;
                    end else if (inc)
                        sh_minutes <= (sh_minutes == 6'd59) ? 6'd0 : sh_minutes + 6'd1;
                    else if (dec)
                        sh_minutes <= (sh_minutes == 6'd0) ? 6'd59 : sh_minutes - 6'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alarm_state = state;

    // Split 0..59 into {tens, ones} BCD without a divider.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] r;
        t = 4'd0;
        r = v;
        if (v >= 6'd50)      begin t = 4'd5; r = v - 6'd50; end
        else if (v >= 6'd40) begin t = 4'd4; r = v - 6'd40; end
        else if (v >= 6'd30) begin t = 4'd3; r = v - 6'd30; end
        else if (v >= 6'd20) begin t = 4'd2; r = v - 6'd20; end
        else if (v >= 6'd10) begin t = 4'd1; r = v - 6'd10; end
        return {t, r[3:0]};
    endfunction

    logic                              editing;
    logic [4:0]                        show_hours;
    logic [5:0]                        show_minutes;
    logic [7:0]                        hour_bcd, min_bcd;
    logic [NUM_DIGITS-1:0][3:0]        digit;
    logic [NUM_DIGITS-1:0]             blank;
    logic [NUM_DIGITS-1:0][6:0]        seg;

    // Display source: shadows only while actively editing, committed otherwise.
    always_comb begin
        editing      = active && (state != IDLE);
        show_hours   = editing ? sh_hours   : alarm_hours;
        show_minutes = editing ? sh_minutes : alarm_minutes;
        hour_bcd     = to_bcd({1'b0, show_hours});
        min_bcd      = to_bcd(show_minutes);
        digit[0]     = hour_bcd[7:4];
        digit[1]     = hour_bcd[3:0];
        digit[2]     = min_bcd[7:4];
        digit[3]     = min_bcd[3:0];
        blank[0]     = editing && (state == SET_HOUR) && !real_quarter;
        blank[1]     = blank[0];
        blank[2]     = editing && (state == SET_MIN) && !real_quarter;
        blank[3]     = blank[2];
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        seg7_digit u_dig (
            .digit(digit[i]),
            .blank(blank[i]),
            .seg  (seg[i])
        );
    end

    assign disp0 = seg[0];
    assign disp1 = seg[1];
    assign disp2 = seg[2];
    assign disp3 = seg[3];
    assign disp4 = 7'b1110111;
    assign disp5 = 7'b0001110;
endmodule

// File: tb/tb_alarm_time_setter.sv
// Directed bench for alarm_time_setter: linear step sequence, immediate
// assertions against hand-computed values.
module tb_alarm_time_setter;
    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] S7 = 7'b1110000;
    localparam logic [6:0] S9 = 7'b1111011;
    localparam logic [6:0] SB = 7'b0000000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] currentMode = 2'd0;
    logic       real_quarter = 1'b1;
    logic       pulsed_set = 1'b0, pulsed_up = 1'b0, pulsed_down = 1'b0;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic [1:0] alarm_state;
    logic [6:0] disp0, disp1, disp2, disp3, disp4, disp5;

    int tests = 0;
    int fails = 0;

    alarm_time_setter dut (
        .clk          (clk),
        .reset        (reset),
        .currentMode  (currentMode),
        .real_quarter (real_quarter),
        .pulsed_set   (pulsed_set),
        .pulsed_up    (pulsed_up),
        .pulsed_down  (pulsed_down),
        .alarm_hours  (alarm_hours),
        .alarm_minutes(alarm_minutes),
        .alarm_state  (alarm_state),
        .disp0        (disp0),
        .disp1        (disp1),
        .disp2        (disp2),
        .disp3        (disp3),
        .disp4        (disp4),
        .disp5        (disp5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One-cycle pulse combination, then outputs are sampled 1 time unit after the edge.
    task automatic press(input logic s, input logic u, input logic d);
        pulsed_set  = s;
        pulsed_up   = u;
        pulsed_down = d;
        @(posedge clk); #1;
        pulsed_set  = 1'b0;
        pulsed_up   = 1'b0;
        pulsed_down = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        // 1: reset state
        repeat (2) idle_cycle();
        reset = 1'b0;
        idle_cycle();
        chk("rst_hours", 7'(alarm_hours), 7'd0);
        chk("rst_minutes", 7'(alarm_minutes), 7'd0);
        chk("rst_state", 7'(alarm_state), 7'd0);
        chk("rst_disp0", disp0, S0);
        chk("rst_disp1", disp1, S0);
        chk("rst_disp2", disp2, S0);
        chk("rst_disp3", disp3, S0);
        chk("rst_disp4", disp4, 7'b1110111);
        chk("rst_disp5", disp5, 7'b0001110);

        // 2: set, up x7, set, down, set -> 07:59
        currentMode = 2'd1;
        press(1, 0, 0);
        chk("t2_state_hour", 7'(alarm_state), 7'd1);
        repeat (7) press(0, 1, 0);
        chk("t2_disp0", disp0, S0);
        chk("t2_disp1", disp1, S7);
        chk("t2_hold_hours", 7'(alarm_hours), 7'd0);
        press(1, 0, 0);
        chk("t2_state_min", 7'(alarm_state), 7'd2);
        press(0, 0, 1);
        chk("t2_disp2", disp2, S5);
        chk("t2_disp3", disp3, S9);
        chk("t2_hold_hours2", 7'(alarm_hours), 7'd0);
        chk("t2_hold_minutes", 7'(alarm_minutes), 7'd0);
        press(1, 0, 0);
        chk("t2_commit_hours", 7'(alarm_hours), 7'd7);
        chk("t2_commit_minutes", 7'(alarm_minutes), 7'd59);
        chk("t2_state_idle", 7'(alarm_state), 7'd0);

        // 3: wraps
        press(1, 0, 0);
        repeat (16) press(0, 1, 0);
        chk("t3_h23_d0", disp0, S2);
        chk("t3_h23_d1", disp1, S3);
        press(0, 1, 0);
        chk("t3_hwrap_d0", disp0, S0);
        chk("t3_hwrap_d1", disp1, S0);
        press(1, 0, 0);
        press(0, 1, 0);
        chk("t3_mwrap_up_d2", disp2, S0);
        chk("t3_mwrap_up_d3", disp3, S0);
        chk("t3_mwrap_hour", disp1, S0);
        press(0, 0, 1);
        chk("t3_mwrap_dn_d2", disp2, S5);
        chk("t3_mwrap_dn_d3", disp3, S9);
        press(1, 0, 0);
        chk("t3_commit_hours", 7'(alarm_hours), 7'd0);
        chk("t3_commit_minutes", 7'(alarm_minutes), 7'd59);

        // 4: abort on mode exit, shadow reload on re-entry
        press(1, 0, 0);
        repeat (5) press(0, 1, 0);
        chk("t4_shadow5", disp1, S5);
        currentMode = 2'd0;
        idle_cycle();
        chk("t4_abort_state", 7'(alarm_state), 7'd0);
        chk("t4_abort_hours", 7'(alarm_hours), 7'd0);
        chk("t4_abort_minutes", 7'(alarm_minutes), 7'd59);
        press(1, 0, 0);
        chk("t4_inactive_set", 7'(alarm_state), 7'd0);
        currentMode = 2'd1;
        press(1, 0, 0);
        chk("t4_reenter_state", 7'(alarm_state), 7'd1);
        chk("t4_reload_d1", disp1, S0);
        chk("t4_reload_d3", disp3, S9);

        // 5: same-cycle events
        press(1, 1, 0);
        chk("t5_setup_state", 7'(alarm_state), 7'd2);
        chk("t5_setup_hour", disp1, S0);
        press(0, 1, 1);
        chk("t5_updown_d2", disp2, S5);
        chk("t5_updown_d3", disp3, S9);
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        chk("t5_rst_state", 7'(alarm_state), 7'd0);
        chk("t5_rst_hours", 7'(alarm_hours), 7'd0);
        chk("t5_rst_minutes", 7'(alarm_minutes), 7'd0);
        press(0, 1, 0);
        chk("t5_idle_up_hours", 7'(alarm_hours), 7'd0);
        chk("t5_idle_up_d1", disp1, S0);

        // 6: blinking of the field under edit
        press(1, 0, 0);
        real_quarter = 1'b0;
        #1;
        chk("t6_hour_blank_d0", disp0, SB);
        chk("t6_hour_blank_d2", disp2, S0);
        real_quarter = 1'b1;
        press(0, 1, 0);
        press(1, 0, 0);
        repeat (3) press(0, 1, 0);
        real_quarter = 1'b0;
        #1;
        chk("t6_blank_d2", disp2, SB);
        chk("t6_blank_d3", disp3, SB);
        chk("t6_steady_d0", disp0, S0);
        chk("t6_steady_d1", disp1, 7'b0110000);
        real_quarter = 1'b1;
        #1;
        chk("t6_show_d2", disp2, S0);
        chk("t6_show_d3", disp3, S3);
        chk("t6_steady_d1b", disp1, 7'b0110000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
